// File: rtl/riscv_dmem_responder.sv
// Data-memory responder for a RISC-V core data port: a fixed number of wait states,
// then a one-cycle completion with a little-endian lane merge on stores and load extension.
module riscv_dmem_responder #(
   parameter int AW       = 5,
   parameter int WAIT_CYC = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] Addr_i,
   input  logic        Rd_en_i,
   input  logic        Wr_en_i,
   input  logic [2:0]  Size_i,
   input  logic [31:0] Wr_data_i,
   output logic [31:0] Read_data_o,
   output logic        Ready_o,
   output logic        Err_o,
   output logic        Busy_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam logic [3:0] LP_WAIT = 4'(WAIT_CYC);

   localparam logic [2:0] SZ_B  = 3'b000;
   localparam logic [2:0] SZ_H  = 3'b001;
   localparam logic [2:0] SZ_W  = 3'b010;
   localparam logic [2:0] SZ_BU = 3'b100;
   localparam logic [2:0] SZ_HU = 3'b101;

   state_t          r_state;
   logic [3:0]      r_cnt;
   logic [AW-1:0]   r_idx;
   logic [1:0]      r_lane;
   logic [2:0]      r_size;
   logic [31:0]     r_wdata;
   logic            r_is_wr;
   logic            r_err;
   logic            r_ready;
   logic            r_err_o;
   logic            r_busy;
   logic [31:0]     r_rdata;
   logic [31:0]     r_mem [0:(2**AW)-1];

   logic            w_accept;
   logic            w_req_err;
   logic            w_do_write;
   logic [31:0]     w_word;
   logic [31:0]     w_load;
   logic [31:0]     w_merged;
   logic            w_unused_addr;

   function automatic logic f_req_err(input logic [1:0] lane, input logic [2:0] size,
                                      input logic rd, input logic wr);
      logic bad;
      case (size)
         SZ_B:    bad = 1'b0;
         SZ_BU:   bad = wr;
         SZ_H:    bad = lane[0];
         SZ_HU:   bad = lane[0] | wr;
         SZ_W:    bad = (lane != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad | (rd & wr);
   endfunction

   function automatic logic [31:0] f_load(input logic [31:0] word, input logic [1:0] lane,
                                          input logic [2:0] size);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] res;
      b = word[{lane, 3'b000} +: 8];
      h = lane[1] ? word[31:16] : word[15:0];
      case (size)
         SZ_B:    res = {{24{b[7]}}, b};
         SZ_H:    res = {{16{h[15]}}, h};
         SZ_W:    res = word;
         SZ_BU:   res = {24'd0, b};
         SZ_HU:   res = {16'd0, h};
         default: res = 32'd0;
      endcase
      return res;
   endfunction

   function automatic logic [31:0] f_merge(input logic [31:0] word, input logic [31:0] data,
                                           input logic [1:0] lane, input logic [2:0] size);
      logic [31:0] res;
      res = word;
      case (size)
         SZ_B: res[{lane, 3'b000} +: 8] = data[7:0];
         SZ_H: begin
            if (lane[1]) begin
               res[31:16] = data[15:0];
            end else begin
               res[15:0] = data[15:0];
            end
         end
         SZ_W:    res = data;
         default: res = word;
      endcase
      return res;
   endfunction

   // Address bits above the memory window are deliberately ignored (addresses wrap).
   assign w_unused_addr = ^Addr_i[31:AW+2];

   assign w_accept   = (r_state == ST_IDLE) & (Rd_en_i | Wr_en_i);
   assign w_req_err  = f_req_err(Addr_i[1:0], Size_i, Rd_en_i, Wr_en_i);
   assign w_word     = r_mem[r_idx];
   assign w_load     = f_load(w_word, r_lane, r_size);
   assign w_merged   = f_merge(w_word, r_wdata, r_lane, r_size);
   assign w_do_write = (r_state == ST_RESP) & r_is_wr & ~r_err & ~rst_i;

   // Storage array: no reset, written only in RESP for a legal store.
   always_ff @(posedge clk_i) begin
      if (w_do_write) begin
         r_mem[r_idx] <= w_merged;
      end
   end

   // Request FSM with registered completion outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
         r_cnt   <= 4'd0;
         r_idx   <= '0;
         r_lane  <= 2'd0;
         r_size  <= 3'd0;
         r_wdata <= 32'd0;
         r_is_wr <= 1'b0;
         r_err   <= 1'b0;
         r_ready <= 1'b0;
         r_err_o <= 1'b0;
         r_busy  <= 1'b0;
         r_rdata <= 32'd0;
      end else begin
         r_ready <= 1'b0;
         r_err_o <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_idx   <= Addr_i[AW+1:2];
                  r_lane  <= Addr_i[1:0];
                  r_size  <= Size_i;
                  r_wdata <= Wr_data_i;
                  r_is_wr <= Wr_en_i;
                  r_err   <= w_req_err;
                  r_busy  <= 1'b1;
                  if (LP_WAIT != 4'd0) begin
                     r_state <= ST_WAIT;
                     r_cnt   <= LP_WAIT;
                  end else begin
                     r_state <= ST_RESP;
                  end
               end
            end
            ST_WAIT: begin
               r_cnt <= r_cnt - 4'd1;
               if (r_cnt <= 4'd1) begin
                  r_state <= ST_RESP;
               end
            end
            ST_RESP: begin
               r_ready <= 1'b1;
               r_err_o <= r_err;
               r_rdata <= (r_err | r_is_wr) ? 32'd0 : w_load;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign Read_data_o = r_rdata;
   assign Ready_o     = r_ready;
   assign Err_o       = r_err_o;
   assign Busy_o      = r_busy;

endmodule

// File: tb/tb_riscv_dmem_responder.sv
// Directed bench: one responder with two wait states and one with none, expected values by hand.
module tb_riscv_dmem_responder;

   localparam logic [2:0] SZ_B  = 3'b000;
   localparam logic [2:0] SZ_H  = 3'b001;
   localparam logic [2:0] SZ_W  = 3'b010;
   localparam logic [2:0] SZ_X  = 3'b011;
   localparam logic [2:0] SZ_BU = 3'b100;
   localparam logic [2:0] SZ_HU = 3'b101;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [31:0] a_addr, a_wdata, a_rdata;
   logic        a_rd, a_wr, a_ready, a_err, a_busy;
   logic [2:0]  a_size;
   logic [31:0] b_addr, b_wdata, b_rdata;
   logic        b_rd, b_wr, b_ready, b_err, b_busy;
   logic [2:0]  b_size;

   int n_checks = 0;
   int n_fail   = 0;

   riscv_dmem_responder #(.AW(5), .WAIT_CYC(2)) u_dut_w2 (
      .clk_i(clk), .rst_i(rst), .Addr_i(a_addr), .Rd_en_i(a_rd), .Wr_en_i(a_wr),
      .Size_i(a_size), .Wr_data_i(a_wdata), .Read_data_o(a_rdata), .Ready_o(a_ready),
      .Err_o(a_err), .Busy_o(a_busy)
   );

   riscv_dmem_responder #(.AW(5), .WAIT_CYC(0)) u_dut_w0 (
      .clk_i(clk), .rst_i(rst), .Addr_i(b_addr), .Rd_en_i(b_rd), .Wr_en_i(b_wr),
      .Size_i(b_size), .Wr_data_i(b_wdata), .Read_data_o(b_rdata), .Ready_o(b_ready),
      .Err_o(b_err), .Busy_o(b_busy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   // One request on the selected DUT, then latency, data, error and pulse-width checks.
   task automatic access(input bit sel, input logic rd, input logic wr, input logic [2:0] sz,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_data, input logic exp_err, input string tag);
      int lat;
      @(negedge clk);
      if (sel) begin
         b_rd = rd; b_wr = wr; b_size = sz; b_addr = addr; b_wdata = wd;
      end else begin
         a_rd = rd; a_wr = wr; a_size = sz; a_addr = addr; a_wdata = wd;
      end
      @(posedge clk); #1;
      a_rd = 1'b0; a_wr = 1'b0; b_rd = 1'b0; b_wr = 1'b0;
      lat = 0;
      while (((sel ? b_ready : a_ready) == 1'b0) && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, "_lat"}, lat, sel ? 32'd1 : 32'd3);
      check({tag, "_data"}, sel ? b_rdata : a_rdata, exp_data);
      check({tag, "_err"}, sel ? b_err : a_err, {31'd0, exp_err});
      @(posedge clk); #1;
      check({tag, "_pulse"}, sel ? b_ready : a_ready, 32'd0);
   endtask

   initial begin : main
      logic seen;
      rst = 1'b1;
      a_rd = 1'b0; a_wr = 1'b0; a_size = 3'd0; a_addr = 32'd0; a_wdata = 32'd0;
      b_rd = 1'b0; b_wr = 1'b0; b_size = 3'd0; b_addr = 32'd0; b_wdata = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", a_ready, 32'd0);
      check("rst_err",   a_err,   32'd0);
      check("rst_busy",  a_busy,  32'd0);
      check("rst_rdata", a_rdata, 32'd0);
      @(negedge clk) rst = 1'b0;

      access(0, 1'b0, 1'b1, SZ_W,  32'h08, 32'hDEADBEEF, 32'h0, 1'b0, "sw08");
      access(0, 1'b1, 1'b0, SZ_W,  32'h08, 32'h0, 32'hDEADBEEF, 1'b0, "lw08");
      access(0, 1'b0, 1'b1, SZ_B,  32'h09, 32'h00000080, 32'h0, 1'b0, "sb09");
      access(0, 1'b1, 1'b0, SZ_B,  32'h09, 32'h0, 32'hFFFFFF80, 1'b0, "lb09");
      access(0, 1'b1, 1'b0, SZ_BU, 32'h09, 32'h0, 32'h00000080, 1'b0, "lbu09");
      access(0, 1'b1, 1'b0, SZ_W,  32'h08, 32'h0, 32'hDEAD80EF, 1'b0, "lw08b");
      access(0, 1'b1, 1'b0, SZ_H,  32'h03, 32'h0, 32'h0, 1'b1, "lh03_mis");
      access(0, 1'b1, 1'b0, SZ_W,  32'h0A, 32'h0, 32'h0, 1'b1, "lw0a_mis");
      access(0, 1'b0, 1'b1, SZ_W,  32'h0A, 32'h1, 32'h0, 1'b1, "sw0a_mis");
      access(0, 1'b1, 1'b0, SZ_W,  32'h08, 32'h0, 32'hDEAD80EF, 1'b0, "lw08c");
      access(0, 1'b1, 1'b0, SZ_H,  32'h0A, 32'h0, 32'hFFFFDEAD, 1'b0, "lh0a");
      access(0, 1'b1, 1'b0, SZ_HU, 32'h0A, 32'h0, 32'h0000DEAD, 1'b0, "lhu0a");
      access(0, 1'b1, 1'b0, SZ_X,  32'h08, 32'h0, 32'h0, 1'b1, "lsz011");
      access(0, 1'b0, 1'b1, SZ_BU, 32'h08, 32'h55, 32'h0, 1'b1, "sbu_err");
      access(0, 1'b1, 1'b1, SZ_W,  32'h08, 32'h0, 32'h0, 1'b1, "rdwr_err");
      access(0, 1'b1, 1'b0, SZ_W,  32'h08, 32'h0, 32'hDEAD80EF, 1'b0, "lw08d");
      access(0, 1'b0, 1'b1, SZ_W,  32'h84, 32'h12345678, 32'h0, 1'b0, "sw84");
      access(0, 1'b1, 1'b0, SZ_W,  32'h04, 32'h0, 32'h12345678, 1'b0, "lw04_wrap");

      // Reset while a store sits in WAIT: it must vanish without a completion.
      @(negedge clk);
      a_wr = 1'b1; a_size = SZ_W; a_addr = 32'h08; a_wdata = 32'hFFFFFFFF;
      @(posedge clk); #1;
      a_wr = 1'b0;
      check("rstw_busy", a_busy, 32'd1);
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("rstw_busy0", a_busy, 32'd0);
      check("rstw_ready0", a_ready, 32'd0);
      seen = 1'b0;
      repeat (6) begin
         @(posedge clk); #1;
         if (a_ready) seen = 1'b1;
      end
      check("rstw_noready", seen, 32'd0);
      access(0, 1'b1, 1'b0, SZ_W, 32'h08, 32'h0, 32'hDEAD80EF, 1'b0, "lw08_rst");

      access(0, 1'b0, 1'b1, SZ_H, 32'h0A, 32'h1234BEEF, 32'h0, 1'b0, "sh0a");
      access(0, 1'b1, 1'b0, SZ_W, 32'h08, 32'h0, 32'hBEEF80EF, 1'b0, "lw08_sh");
      access(0, 1'b1, 1'b0, SZ_B, 32'h0B, 32'h0, 32'hFFFFFFBE, 1'b0, "lb0b");
      access(0, 1'b1, 1'b0, SZ_H, 32'h08, 32'h0, 32'hFFFF80EF, 1'b0, "lh08");

      // A store pulsed while a load is in flight must be ignored.
      @(negedge clk);
      a_rd = 1'b1; a_size = SZ_W; a_addr = 32'h08;
      @(posedge clk); #1;
      a_rd = 1'b0; a_wr = 1'b1; a_wdata = 32'h0;
      @(posedge clk); #1;
      a_wr = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("ign_busy", a_busy, 32'd0);
      access(0, 1'b1, 1'b0, SZ_W, 32'h08, 32'h0, 32'hBEEF80EF, 1'b0, "lw08_ign");

      // Zero wait states: completion one cycle after acceptance, second pulse ignored.
      access(1, 1'b0, 1'b1, SZ_W, 32'h10, 32'hCAFEF00D, 32'h0, 1'b0, "w0_sw");
      access(1, 1'b1, 1'b0, SZ_W, 32'h10, 32'h0, 32'hCAFEF00D, 1'b0, "w0_lw");
      @(negedge clk);
      b_rd = 1'b1; b_size = SZ_W; b_addr = 32'h10;
      @(posedge clk); #1;
      check("w0_busy", b_busy, 32'd1);
      check("w0_rdy_early", b_ready, 32'd0);
      @(posedge clk); #1;
      b_rd = 1'b0;
      check("w0_rdy", b_ready, 32'd1);
      check("w0_data", b_rdata, 32'hCAFEF00D);
      check("w0_busy_resp", b_busy, 32'd0);
      @(posedge clk); #1;
      check("w0_rdy_end", b_ready, 32'd0);
      check("w0_busy_end", b_busy, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
